game_round_ctl: RTL and testbench

Parametrised successor to the fixed four-screen game state machine. It sequences IDLE -> WAIT -> GAME -> SCORE, and times the game round in video frames counted from vsync. It also owns the saturating local score counter, captures the opponent score, and produces the winner code. It sits in the pclk domain between the mouse/click logic, the UART link, and the per-screen draw/ROM blocks, which select on its state output.

---
 rtl/game_round_ctl_if.sv | 30 +++
 rtl/game_round_ctl.sv | 189 ++++++++++++++++++
 tb/tb_game_round_ctl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/game_round_ctl_if.sv
// Control/status bundle between game_round_ctl and its neighbours.
// The controller takes the slave view; the stimulus side takes the master view.
interface game_round_ctl_if #(
  parameter int SCORE_W = 7,
  parameter int TIMER_W = 12
);
  logic               vsync_in;
  logic               play_clicked;
  logic               op_ready;
  logic               duck_hit;
  logic               stop_req;
  logic [SCORE_W-1:0] op_score_in;
  logic               op_score_valid;
  logic [1:0]         state;
  logic [TIMER_W-1:0] frames_left;
  logic [SCORE_W-1:0] my_score;
  logic [SCORE_W-1:0] op_score;
  logic [1:0]         winner;
  logic               round_done;

  modport master (
    output vsync_in, play_clicked, op_ready, duck_hit, stop_req, op_score_in, op_score_valid,
    input  state, frames_left, my_score, op_score, winner, round_done
  );

  modport slave (
    input  vsync_in, play_clicked, op_ready, duck_hit, stop_req, op_score_in, op_score_valid,
    output state, frames_left, my_score, op_score, winner, round_done
  );
endinterface

// File: rtl/game_round_ctl.sv
// Round sequencer IDLE -> WAIT -> GAME -> SCORE: frame-timed round, saturating
// local score, opponent score capture and winner decision.
module game_round_ctl #(
  parameter int SCORE_W           = 7,
  parameter int SCORE_MAX         = 99,
  parameter int TIMER_W           = 12,
  parameter int GAME_FRAMES       = 1800,
  parameter int OP_TIMEOUT_FRAMES = 600
) (
  input  logic            pclk,
  input  logic            rst,
  game_round_ctl_if.slave bus
);

  localparam int TO_W = $clog2(OP_TIMEOUT_FRAMES + 1);
  localparam logic [SCORE_W-1:0] SMAX        = SCORE_W'(SCORE_MAX);
  localparam logic [TIMER_W-1:0] FRAMES_INIT = TIMER_W'(GAME_FRAMES);
  localparam logic [TO_W-1:0]    TO_LIMIT    = TO_W'(OP_TIMEOUT_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GAME  = 2'd2,
    ST_SCORE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] frames_q, frames_d;
  logic [SCORE_W-1:0] my_q, my_d;
  logic [SCORE_W-1:0] op_q, op_d;
  logic [1:0]         win_q, win_d;
  logic               done_q, done_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               rcvd_q, rcvd_d;
  logic               v_q, v_vld_q, s_q;
  logic               tick, stop_rise;

  function automatic logic [1:0] win_code(input logic [SCORE_W-1:0] mine,
                                          input logic [SCORE_W-1:0] theirs);
    if (mine > theirs) begin
      return 2'd1;
    end else if (mine < theirs) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

  function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] raw);
    if (raw > SMAX) begin
      return SMAX;
    end else begin
      return raw;
    end
  endfunction

  // v_vld_q masks the first edge after reset so a vsync already high is not a frame
  assign tick      = bus.vsync_in & ~v_q & v_vld_q;
  assign stop_rise = bus.stop_req & ~s_q;

  // State, round data and input edge history
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      frames_q <= '0;
      my_q     <= '0;
      op_q     <= '0;
      win_q    <= 2'd0;
      done_q   <= 1'b0;
      to_q     <= '0;
      rcvd_q   <= 1'b0;
      v_q      <= 1'b0;
      v_vld_q  <= 1'b0;
      s_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      frames_q <= frames_d;
      my_q     <= my_d;
      op_q     <= op_d;
      win_q    <= win_d;
      done_q   <= done_d;
      to_q     <= to_d;
      rcvd_q   <= rcvd_d;
      v_q      <= bus.vsync_in;
      v_vld_q  <= 1'b1;
      s_q      <= bus.stop_req;
    end
  end

  // Next-state and round bookkeeping
  always_comb begin
    state_d  = state_q;
    frames_d = frames_q;
    my_d     = my_q;
    op_d     = op_q;
    win_d    = win_q;
    done_d   = 1'b0;
    to_d     = to_q;
    rcvd_d   = rcvd_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.play_clicked) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (bus.op_ready) begin
          state_d  = ST_GAME;
          frames_d = FRAMES_INIT;
          my_d     = '0;
          op_d     = '0;
          win_d    = 2'd0;
          rcvd_d   = 1'b0;
        end else if (bus.stop_req) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_GAME: begin
        if (tick && (frames_q <= TIMER_W'(1))) begin
          frames_d = '0;
          state_d  = ST_SCORE;
          done_d   = 1'b1;
          to_d     = '0;
        end else if (tick) begin
          frames_d = frames_q - TIMER_W'(1);
        end else begin
          frames_d = frames_q;
        end
        if (bus.duck_hit && (my_q < SMAX)) begin
          my_d = my_q + SCORE_W'(1);
        end else begin
          my_d = my_q;
        end
        if (bus.op_score_valid) begin
          op_d   = clamp_score(bus.op_score_in);
          rcvd_d = 1'b1;
        end else begin
          op_d   = op_q;
        end
      end

      ST_SCORE: begin
        // Once the opponent has reported, the comparison owns winner
        if (rcvd_q) begin
          win_d = win_code(my_q, op_q);
        end else if (tick && (to_q < TO_LIMIT)) begin
          to_d = to_q + TO_W'(1);
          if ((to_q + TO_W'(1)) == TO_LIMIT) begin
            win_d = 2'd1;
          end else begin
            win_d = win_q;
          end
        end else begin
          win_d = win_q;
        end
        if (bus.op_score_valid) begin
          op_d   = clamp_score(bus.op_score_in);
          rcvd_d = 1'b1;
        end else begin
          op_d   = op_q;
        end
        if (stop_rise && (win_q != 2'd0)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SCORE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.state       = state_q;
  assign bus.frames_left = frames_q;
  assign bus.my_score    = my_q;
  assign bus.op_score    = op_q;
  assign bus.winner      = win_q;
  assign bus.round_done  = done_q;

endmodule

// File: tb/tb_game_round_ctl.sv
// Directed round scenarios plus randomized traffic, checked against a
// rule-level model of the round controller.
module tb_game_round_ctl;
  localparam int SW   = 7;
  localparam int SMAX = 99;
  localparam int TW   = 4;
  localparam int GF   = 3;
  localparam int OTO  = 2;

  logic pclk = 1'b0;
  logic rst;

  game_round_ctl_if #(.SCORE_W(SW), .TIMER_W(TW)) bus ();

  game_round_ctl #(
    .SCORE_W(SW), .SCORE_MAX(SMAX), .TIMER_W(TW),
    .GAME_FRAMES(GF), .OP_TIMEOUT_FRAMES(OTO)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_bad = 0;

  // model of the externally visible round state
  int m_state, m_frames, m_my, m_op, m_win, m_done;
  int m_to, m_rcvd, m_vprev, m_sprev, m_armed;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk_eq({tag, ".state"},      int'(bus.state),       m_state);
    chk_eq({tag, ".frames"},     int'(bus.frames_left), m_frames);
    chk_eq({tag, ".my_score"},   int'(bus.my_score),    m_my);
    chk_eq({tag, ".op_score"},   int'(bus.op_score),    m_op);
    chk_eq({tag, ".winner"},     int'(bus.winner),      m_win);
    chk_eq({tag, ".round_done"}, int'(bus.round_done),  m_done);
  endtask

  function automatic int clamp(input int v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_frames = 0; m_my = 0; m_op = 0; m_win = 0; m_done = 0;
    m_to = 0; m_rcvd = 0; m_vprev = 0; m_sprev = 0; m_armed = 0;
  endtask

  task automatic model_step(input bit vs, input bit play, input bit opr, input bit hit,
                            input bit stop, input int osi, input bit osv);
    bit tick, rise;
    int o_state, o_frames, o_my, o_op, o_win, o_rcvd, o_to;
    o_state = m_state; o_frames = m_frames; o_my = m_my; o_op = m_op;
    o_win = m_win; o_rcvd = m_rcvd; o_to = m_to;
    tick   = vs && !m_vprev && m_armed;
    rise   = stop && !m_sprev;
    m_done = 0;
    if (o_state == 0) begin
      if (play) m_state = 1;
    end else if (o_state == 1) begin
      if (opr) begin
        m_state = 2; m_frames = GF; m_my = 0; m_op = 0; m_win = 0; m_rcvd = 0;
      end else if (stop) begin
        m_state = 0;
      end
    end else if (o_state == 2) begin
      if (tick) begin
        if (o_frames <= 1) begin
          m_frames = 0; m_state = 3; m_done = 1; m_to = 0;
        end else begin
          m_frames = o_frames - 1;
        end
      end
      if (hit) m_my = clamp(o_my + 1);
      if (osv) begin m_op = clamp(osi); m_rcvd = 1; end
    end else begin
      if (o_rcvd) begin
        m_win = (o_my > o_op) ? 1 : ((o_my < o_op) ? 2 : 3);
      end else if (tick && o_to < OTO) begin
        m_to = o_to + 1;
        if (m_to == OTO) m_win = 1;
      end
      if (osv) begin m_op = clamp(osi); m_rcvd = 1; end
      if (rise && o_win != 0) m_state = 0;
    end
    m_vprev = vs; m_sprev = stop; m_armed = 1;
  endtask

  // drive one cycle of inputs (called just after a falling edge), then check
  task automatic cyc(input string tag, input bit vs, input bit play, input bit opr,
                     input bit hit, input bit stop, input int osi, input bit osv);
    bus.vsync_in       = vs;
    bus.play_clicked   = play;
    bus.op_ready       = opr;
    bus.duck_hit       = hit;
    bus.stop_req       = stop;
    bus.op_score_in    = SW'(osi);
    bus.op_score_valid = osv;
    model_step(vs, play, opr, hit, stop, osi & 127, osv);
    @(negedge pclk);
    chk_all(tag);
  endtask

  bit vs_lvl, stop_lvl;

  initial begin
    rst = 1'b1;
    bus.vsync_in = 1'b0; bus.play_clicked = 1'b0; bus.op_ready = 1'b0;
    bus.duck_hit = 1'b0; bus.stop_req = 1'b0; bus.op_score_in = '0;
    bus.op_score_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge pclk);
    chk_all("reset");
    rst = 1'b0;
    @(negedge pclk);
    chk_all("post_reset");

    // Round A: saturation, frame countdown, opponent timeout, exit on stop edge
    cyc("a_play", 0, 1, 0, 0, 0, 0, 0);
    chk_eq("a_wait_state", int'(bus.state), 1);
    cyc("a_start", 0, 0, 1, 0, 0, 0, 0);
    chk_eq("a_game_state", int'(bus.state), 2);
    chk_eq("a_frames_init", int'(bus.frames_left), GF);
    for (int i = 0; i < SMAX + 6; i++) cyc("a_hit", 0, 0, 0, 1, 0, 0, 0);
    chk_eq("a_my_sat", int'(bus.my_score), SMAX);
    for (int i = 0; i < GF; i++) begin
      cyc("a_tick", 1, 0, 0, 0, 0, 0, 0);
      chk_eq("a_frames_dec", int'(bus.frames_left), GF - 1 - i);
      cyc("a_low", 0, 0, 0, 0, 0, 0, 0);
      chk_eq("a_done_pulse", int'(bus.round_done), 0);
    end
    chk_eq("a_score_state", int'(bus.state), 3);
    for (int i = 0; i < OTO; i++) begin
      chk_eq("a_win_pending", int'(bus.winner), 0);
      cyc("a_to_tick", 1, 0, 0, 0, 0, 0, 0);
      cyc("a_to_low", 0, 0, 0, 0, 0, 0, 0);
    end
    chk_eq("a_win_timeout", int'(bus.winner), 1);
    cyc("a_extra_tick", 1, 0, 0, 0, 0, 0, 0);
    chk_eq("a_frames_hold", int'(bus.frames_left), 0);
    cyc("a_stop", 0, 0, 0, 0, 1, 0, 0);
    chk_eq("a_idle_state", int'(bus.state), 0);
    chk_eq("a_my_held", int'(bus.my_score), SMAX);
    cyc("a_stop_low", 0, 0, 0, 0, 0, 0, 0);

    // Round B: hit on the final tick, stop level held over, capture and re-capture
    cyc("b_play", 0, 1, 0, 0, 0, 0, 0);
    cyc("b_start", 0, 0, 1, 0, 0, 0, 0);
    chk_eq("b_my_clear", int'(bus.my_score), 0);
    for (int i = 0; i < GF; i++) begin
      cyc("b_hit", 0, 0, 0, 1, 1, 0, 0);
      cyc("b_tick", 1, 0, 0, (i == GF - 1), 1, 0, 0);
    end
    chk_eq("b_my_final_hit", int'(bus.my_score), GF + 1);
    chk_eq("b_done", int'(bus.round_done), 1);
    cyc("b_cap4", 0, 0, 0, 0, 1, 4, 1);
    chk_eq("b_op4", int'(bus.op_score), 4);
    cyc("b_cmp", 0, 0, 0, 0, 1, 0, 0);
    chk_eq("b_win_tie", int'(bus.winner), 3);
    chk_eq("b_level_no_exit", int'(bus.state), 3);
    cyc("b_cap120", 0, 0, 0, 0, 1, 120, 1);
    chk_eq("b_op_clamp", int'(bus.op_score), SMAX);
    cyc("b_cmp2", 0, 0, 0, 0, 0, 0, 0);
    chk_eq("b_win_op", int'(bus.winner), 2);
    cyc("b_stop", 0, 0, 0, 0, 1, 0, 0);
    chk_eq("b_idle", int'(bus.state), 0);
    cyc("b_stop_low", 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a round
    cyc("r_play", 0, 1, 0, 0, 0, 0, 0);
    cyc("r_start", 0, 0, 1, 0, 0, 0, 0);
    cyc("r_hit", 0, 0, 0, 1, 0, 0, 0);
    bus.vsync_in = 1'b1; bus.duck_hit = 1'b1;
    model_step(1, 0, 0, 1, 0, 0, 0);
    @(posedge pclk);
    #2 rst = 1'b1;
    model_reset();
    #1 chk_all("async_rst");
    bus.duck_hit = 1'b0;
    repeat (2) @(negedge pclk);
    chk_all("rst_hold");
    rst = 1'b0;
    cyc("rel_vs_high", 1, 0, 0, 0, 0, 0, 0);
    cyc("rel_next", 1, 0, 0, 0, 0, 0, 0);

    // Randomized traffic
    vs_lvl = 1'b1; stop_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) < 30) vs_lvl = ~vs_lvl;
      if ($urandom_range(99) < 15) stop_lvl = ~stop_lvl;
      cyc("rand", vs_lvl, ($urandom_range(99) < 20), ($urandom_range(99) < 20),
          ($urandom_range(99) < 30), stop_lvl, int'($urandom_range(127)),
          ($urandom_range(99) < 10));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
